// File: rtl/mp_queue.sv
// rtl/mp_queue.sv - multi-lane circular FIFO with occupancy reporting and single-cycle flush
// Up to NLANE entries in and out per cycle; any DEPTH, full/empty taken from an explicit count.
module mp_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8,
    parameter int NLANE = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int LW = $clog2(NLANE + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [LW-1:0]          enq_cnt,
    input  logic [NLANE*WIDTH-1:0] wdata,
    output logic                   enq_accept,
    input  logic [LW-1:0]          deq_cnt,
    output logic [NLANE*WIDTH-1:0] rdata,
    output logic [NLANE-1:0]       rvalid,
    output logic                   deq_accept,
    output logic [CW-1:0]          count,
    output logic [CW-1:0]          free,
    output logic                   empty,
    output logic                   full
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_P = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW-1:0]    wr_idx [NLANE];
    logic [PW-1:0]    rd_idx [NLANE];
    logic [CW-1:0]    enq_add;
    logic [CW-1:0]    deq_sub;

    // One extra bit holds ptr+k before the conditional wrap, so any DEPTH works.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [PW:0] k);
        logic [PW:0] s;
        s = {1'b0, p} + k;
        if (s >= DEPTH_P) begin
            s = s - DEPTH_P;
        end
        return s[PW-1:0];
    endfunction

    assign free  = CW'(DEPTH) - count;
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    assign enq_accept = (enq_cnt != '0) && (CW'(enq_cnt) <= free) && !flush;
    assign deq_accept = (deq_cnt != '0) && (CW'(deq_cnt) <= count) && !flush;

    assign enq_add = enq_accept ? CW'(enq_cnt) : '0;
    assign deq_sub = deq_accept ? CW'(deq_cnt) : '0;

    always_comb begin
        for (int i = 0; i < NLANE; i++) begin
            wr_idx[i] = ptr_add(tail, (PW + 1)'(i));
            rd_idx[i] = ptr_add(head, (PW + 1)'(i));
        end
    end

    // Zero-latency read; lanes beyond the occupancy read as zero.
    always_comb begin
        rdata  = '0;
        rvalid = '0;
        for (int i = 0; i < NLANE; i++) begin
            rvalid[i] = (count > CW'(i));
            if (rvalid[i]) begin
                rdata[i*WIDTH +: WIDTH] = mem[rd_idx[i]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && enq_accept) begin
            for (int i = 0; i < NLANE; i++) begin
                if (LW'(i) < enq_cnt) begin
                    mem[wr_idx[i]] <= wdata[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq_accept) begin
                tail <= ptr_add(tail, (PW + 1)'(enq_cnt));
            end
            if (deq_accept) begin
                head <= ptr_add(head, (PW + 1)'(deq_cnt));
            end
            count <= count + enq_add - deq_sub;
        end
    end

endmodule

// File: tb/tb_mp_queue.sv
// tb/tb_mp_queue.sv - directed and randomized check of mp_queue against a queue-based model
module tb_mp_queue;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic [1:0]   enq_cnt;
    logic [127:0] wdata;
    logic         enq_accept;
    logic [1:0]   deq_cnt;
    logic [127:0] rdata;
    logic [1:0]   rvalid;
    logic         deq_accept;
    logic [3:0]   count;
    logic [3:0]   free;
    logic         empty;
    logic         full;

    logic [1:0]   e5;
    logic [1:0]   d5;
    logic [31:0]  w5;
    logic         ea5;
    logic         da5;
    logic [31:0]  rd5;
    logic [1:0]   rv5;
    logic [2:0]   cnt5;
    logic [2:0]   free5;
    logic         empty5;
    logic         full5;

    int checks   = 0;
    int failures = 0;
    logic [63:0] q[$];

    always #5 clk = ~clk;

    mp_queue #(.WIDTH(64), .DEPTH(8), .NLANE(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_cnt(enq_cnt), .wdata(wdata), .enq_accept(enq_accept),
        .deq_cnt(deq_cnt), .rdata(rdata), .rvalid(rvalid), .deq_accept(deq_accept),
        .count(count), .free(free), .empty(empty), .full(full)
    );

    mp_queue #(.WIDTH(16), .DEPTH(5), .NLANE(2)) dut5 (
        .clk(clk), .rst(rst), .flush(1'b0),
        .enq_cnt(e5), .wdata(w5), .enq_accept(ea5),
        .deq_cnt(d5), .rdata(rd5), .rvalid(rv5), .deq_accept(da5),
        .count(cnt5), .free(free5), .empty(empty5), .full(full5)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        int sz;
        sz = q.size();
        chk("count", 64'(count), 64'(sz));
        chk("free", 64'(free), 64'(8 - sz));
        chk("empty", 64'(empty), 64'(sz == 0));
        chk("full", 64'(full), 64'(sz == 8));
        chk("rvalid", 64'(rvalid), {62'd0, sz > 1, sz > 0});
        chk("rdata0", rdata[63:0], (sz > 0) ? q[0] : 64'd0);
        chk("rdata1", rdata[127:64], (sz > 1) ? q[1] : 64'd0);
    endtask

    // Drive one cycle; accept decisions come from the start-of-cycle occupancy.
    task automatic step(input logic r, input logic f, input int ec, input int dc,
                        input logic [63:0] d0, input logic [63:0] d1);
        int   sz;
        logic exp_ea;
        logic exp_da;
        assert (ec >= 0 && ec <= 2 && dc >= 0 && dc <= 2);
        rst     = r;
        flush   = f;
        enq_cnt = ec[1:0];
        deq_cnt = dc[1:0];
        wdata   = {d1, d0};
        #1;
        sz     = q.size();
        exp_ea = (ec != 0) && (ec <= 8 - sz) && !f;
        exp_da = (dc != 0) && (dc <= sz) && !f;
        chk("enq_accept", 64'(enq_accept), 64'(exp_ea));
        chk("deq_accept", 64'(deq_accept), 64'(exp_da));
        check_state();
        @(posedge clk);
        #1;
        if (r || f) begin
            q.delete();
        end else begin
            if (exp_da) repeat (dc) void'(q.pop_front());
            if (exp_ea) begin
                q.push_back(d0);
                if (ec == 2) q.push_back(d1);
            end
        end
        rst = 1'b0; flush = 1'b0; enq_cnt = 2'd0; deq_cnt = 2'd0;
    endtask

    task automatic step5(input int ec, input int dc, input logic [15:0] a, input logic [15:0] b);
        e5 = ec[1:0];
        d5 = dc[1:0];
        w5 = {b, a};
        @(posedge clk);
        #1;
        e5 = 2'd0;
        d5 = 2'd0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; enq_cnt = 2'd0; deq_cnt = 2'd0; wdata = '0;
        e5 = 2'd0; d5 = 2'd0; w5 = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_free", 64'(free), 64'd8);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_rdata", rdata[63:0] | rdata[127:64], 64'd0);

        // Fill to full in pairs, then an extra single enqueue must bounce.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 2, 0, 64'hA000 + 64'(2 * i), 64'hA000 + 64'(2 * i + 1));
        end
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_count", 64'(count), 64'd8);
        chk("fill_free", 64'(free), 64'd0);
        step(1'b0, 1'b0, 1, 0, 64'hDEAD, 64'hBEEF);
        chk("full_reject_count", 64'(count), 64'd8);
        chk("full_reject_head", rdata[63:0], 64'hA000);

        step(1'b0, 1'b0, 2, 2, 64'hB000, 64'hB001);
        chk("full_swap_count", 64'(count), 64'd6);
        chk("full_swap_head", rdata[63:0], 64'hA002);
        step(1'b0, 1'b0, 2, 0, 64'hB002, 64'hB003);
        chk("refill_count", 64'(count), 64'd8);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 0, 1, 64'd0, 64'd0);
        chk("drain_last", rdata[63:0], 64'hB003);

        step(1'b0, 1'b0, 0, 2, 64'd0, 64'd0);
        chk("underflow_count", 64'(count), 64'd1);
        step(1'b0, 1'b0, 0, 1, 64'd0, 64'd0);
        chk("drain_empty", 64'(empty), 64'd1);

        step(1'b0, 1'b0, 2, 0, 64'hC000, 64'hC001);
        step(1'b0, 1'b0, 2, 0, 64'hC002, 64'hC003);
        step(1'b0, 1'b0, 1, 0, 64'hC004, 64'd0);
        chk("pre_flush_count", 64'(count), 64'd5);
        step(1'b0, 1'b1, 2, 1, 64'hE000, 64'hE001);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_empty", 64'(empty), 64'd1);
        chk("flush_rdata", rdata[63:0], 64'd0);
        step(1'b0, 1'b0, 1, 0, 64'hF000, 64'd0);
        chk("post_flush_head", rdata[63:0], 64'hF000);

        for (int n = 0; n < 10000; n++) begin
            step(($urandom_range(0, 999) == 0), ($urandom_range(0, 63) == 0),
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                 {$urandom, $urandom}, {$urandom, $urandom});
        end
        #1;
        check_state();

        // DEPTH=5: push head/tail to index 4 so the next writes straddle 4 -> 0 -> 1.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        step5(2, 0, 16'h10, 16'h11);
        step5(2, 0, 16'h12, 16'h13);
        chk("d5_count4", 64'(cnt5), 64'd4);
        chk("d5_head", 64'(rd5[15:0]), 64'h10);
        step5(0, 2, 16'h0, 16'h0);
        step5(0, 2, 16'h0, 16'h0);
        chk("d5_empty", 64'(empty5), 64'd1);
        step5(2, 0, 16'h1, 16'h2);
        step5(1, 0, 16'h3, 16'h0);
        chk("d5_wrap_count", 64'(cnt5), 64'd3);
        chk("d5_wrap_lane0", 64'(rd5[15:0]), 64'h1);
        chk("d5_wrap_lane1", 64'(rd5[31:16]), 64'h2);
        chk("d5_free", 64'(free5), 64'd2);
        step5(0, 2, 16'h0, 16'h0);
        chk("d5_tail_lane0", 64'(rd5[15:0]), 64'h3);
        chk("d5_tail_lane1", 64'(rd5[31:16]), 64'h0);
        chk("d5_tail_rvalid", 64'(rv5), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
